// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, instruction decode, 32-entry register file,
// branch/jump resolution with MEM forwarding, hazard detection and the ID/EX register.
module decode_stage #(
  parameter int          NUM_REGS   = 32,
  parameter logic [31:0] RESET_INST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instruction,
  input  logic [31:0] if_pc_next,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_alu_result,
  output logic [1:0]  pc_src,
  output logic [31:0] jump_address,
  output logic [31:0] branch_address,
  output logic        stall,
  output logic        id_ex_valid,
  output logic [31:0] id_ex_pc_next,
  output logic [31:0] id_ex_rs_data,
  output logic [31:0] id_ex_rt_data,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd,
  output logic [5:0]  id_ex_funct,
  output logic        id_ex_reg_write,
  output logic        id_ex_mem_read,
  output logic        id_ex_mem_write,
  output logic        id_ex_alu_src
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_next;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
  } idex_t;

  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  idex_t       idex_q, idex_d;
  logic [31:0] regs_q [NUM_REGS];

  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, dest;
  logic [31:0] imm_sext, rs_val, rt_val, br_a, br_b;
  logic        is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_br;
  logic        uses_rs, uses_rt;
  logic        load_use, br_ex_haz, br_mem_haz, taken, flush;

  assign op       = ifid_instr_q[31:26];
  assign rs       = ifid_instr_q[25:21];
  assign rt       = ifid_instr_q[20:16];
  assign rd       = ifid_instr_q[15:11];
  assign imm_sext = {{16{ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  assign is_r    = (op == OP_RTYPE);
  assign is_addi = (op == OP_ADDI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_br   = is_beq | is_bne;
  assign uses_rs = is_r | is_addi | is_lw | is_sw | is_br;
  assign uses_rt = is_r | is_sw | is_br;
  assign dest    = is_r ? rd : ((is_addi | is_lw) ? rt : 5'd0);

  // Register reads see a same-cycle writeback; r0 always reads zero.
  always_comb begin
    rs_val = regs_q[rs];
    rt_val = regs_q[rt];
    if (rs == 5'd0) rs_val = '0;
    else if (wb_reg_write && wb_rd == rs) rs_val = wb_data;
    if (rt == 5'd0) rt_val = '0;
    else if (wb_reg_write && wb_rd == rt) rt_val = wb_data;
  end

  always_comb begin
    br_a = rs_val;
    br_b = rt_val;
    if (mem_reg_write && !mem_mem_read && mem_rd == rs && rs != 5'd0) br_a = mem_alu_result;
    if (mem_reg_write && !mem_mem_read && mem_rd == rt && rt != 5'd0) br_b = mem_alu_result;
  end

  assign load_use   = idex_q.mem_read && idex_q.rd != 5'd0 &&
                      ((uses_rs && idex_q.rd == rs) || (uses_rt && idex_q.rd == rt));
  assign br_ex_haz  = is_br && idex_q.reg_write && idex_q.rd != 5'd0 &&
                      (idex_q.rd == rs || idex_q.rd == rt);
  assign br_mem_haz = is_br && mem_mem_read && mem_rd != 5'd0 &&
                      (mem_rd == rs || mem_rd == rt);
  assign stall      = ifid_valid_q && (load_use || br_ex_haz || br_mem_haz);
  assign taken      = (is_beq && br_a == br_b) || (is_bne && br_a != br_b);

  // Stall wins over any redirect; fetch is holding its PC anyway.
  always_comb begin
    pc_src = 2'b00;
    if (ifid_valid_q && !stall) begin
      if (is_j)       pc_src = 2'b01;
      else if (taken) pc_src = 2'b10;
    end
  end

  assign flush          = (pc_src != 2'b00);
  assign jump_address   = {ifid_pc_q[31:28], ifid_instr_q[25:0], 2'b00};
  assign branch_address = ifid_pc_q + {imm_sext[29:0], 2'b00};

  always_comb begin
    ifid_instr_d = if_instruction;
    ifid_pc_d    = if_pc_next;
    ifid_valid_d = 1'b1;
    if (stall) begin
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_valid_d = ifid_valid_q;
    end else if (flush) begin
      ifid_instr_d = RESET_INST;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end
  end

  // Invalid or stalled slots become an all-zero bubble.
  always_comb begin
    idex_d = '0;
    if (ifid_valid_q && !stall) begin
      idex_d.valid     = 1'b1;
      idex_d.pc_next   = ifid_pc_q;
      idex_d.rs_data   = rs_val;
      idex_d.rt_data   = rt_val;
      idex_d.imm       = imm_sext;
      idex_d.rs        = rs;
      idex_d.rt        = rt;
      idex_d.rd        = dest;
      idex_d.funct     = ifid_instr_q[5:0];
      idex_d.reg_write = is_r | is_addi | is_lw;
      idex_d.mem_read  = is_lw;
      idex_d.mem_write = is_sw;
      idex_d.alu_src   = is_addi | is_lw | is_sw;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid_instr_q <= RESET_INST;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
    end else begin
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_reg_write && wb_rd != 5'd0) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  assign id_ex_valid     = idex_q.valid;
  assign id_ex_pc_next   = idex_q.pc_next;
  assign id_ex_rs_data   = idex_q.rs_data;
  assign id_ex_rt_data   = idex_q.rt_data;
  assign id_ex_imm       = idex_q.imm;
  assign id_ex_rs        = idex_q.rs;
  assign id_ex_rt        = idex_q.rt;
  assign id_ex_rd        = idex_q.rd;
  assign id_ex_funct     = idex_q.funct;
  assign id_ex_reg_write = idex_q.reg_write;
  assign id_ex_mem_read  = idex_q.mem_read;
  assign id_ex_mem_write = idex_q.mem_write;
  assign id_ex_alu_src   = idex_q.alu_src;

endmodule
